// File: rtl/pipelined_addsub.sv
`default_nettype none
//============================================================================
// Module   : pipelined_addsub
// Purpose  : n-bit adder/subtractor split into k pipeline stages. Stage j
//            adds chunk j (c = n/k bits) using the carry from stage j-1, so
//            the carry ripple per cycle is only c bits long. The last stage
//            also derives signed overflow, optional signed saturation and
//            the zero/negative flags, all registered with the result.
//            A global ready/valid stall freezes every stage at once.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   n          operand / result width (must be a multiple of k)
//   k          number of pipeline stages (k = 1 -> single registered stage)
// Ports
//   Clock      rising-edge clock
//   Resetn     synchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational)
//   Sub        0 = X + Y + carryin, 1 = X - Y - carryin
//   Sat        clamp signed overflow to the signed extreme
//   carryin    carry-in (add) / borrow-in (sub)
//   X, Y       operands
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   S          result (after saturation)
//   carryout   raw carry out of bit n-1 (sub: 1 = no borrow)
//   overflow   signed overflow of the raw sum
//   zero       S == 0
//   neg        S[n-1]
//============================================================================
module pipelined_addsub #(
    parameter int n = 32,
    parameter int k = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         Sub,
    input  logic         Sat,
    input  logic         carryin,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] S,
    output logic         carryout,
    output logic         overflow,
    output logic         zero,
    output logic         neg
);

    localparam int c_cw = n / k;

    if ((k < 1) || ((n % k) != 0)) begin : g_param_check
        $error("pipelined_addsub: n (%0d) must be a non-zero multiple of k (%0d)", n, k);
    end

    //------------------------------------------------------------------------
    // Stage inputs. Element j is what stage j consumes this cycle: the port
    // side for j = 0, the registers of stage j-1 otherwise. Operands carry
    // the full width forward so the operand MSBs reach the final stage.
    //------------------------------------------------------------------------
    logic [n-1:0] w_xin   [k];
    logic [n-1:0] w_yin   [k];
    logic [n-1:0] w_sumin [k];
    logic         w_cin   [k];
    logic         w_satin [k];
    logic         w_vin   [k];

    // Inter-stage registers (element k-1 of the data arrays is not needed:
    // the last stage registers straight into the output registers).
    logic [n-1:0] r_x     [k];
    logic [n-1:0] r_y     [k];
    logic [n-1:0] r_sum   [k];
    logic         r_c     [k];
    logic         r_sat   [k];
    logic         r_v     [k];

    // Output registers.
    logic [n-1:0] r_s;
    logic         r_co;
    logic         r_ovf;
    logic         r_zero;
    logic         r_neg;

    logic         w_adv;
    logic [n-1:0] w_yeff;

    // Global stall: nothing moves unless the output slot is free or draining.
    assign w_adv    = ~r_v[k-1] | out_ready;
    assign in_ready = w_adv;

    // Subtraction is X + ~Y + ~borrow, so both the operand and the carry-in
    // are inverted by Sub.
    assign w_yeff = Y ^ {n{Sub}};

    assign w_xin[0]   = X;
    assign w_yin[0]   = w_yeff;
    assign w_sumin[0] = '0;
    assign w_cin[0]   = carryin ^ Sub;
    assign w_satin[0] = Sat;
    assign w_vin[0]   = in_valid;

    //------------------------------------------------------------------------
    // Pipeline stages
    //------------------------------------------------------------------------
    for (genvar j = 0; j < k; j++) begin : g_stage
        logic [c_cw:0] w_chunk;
        logic [n-1:0]  w_sum;

        // Chunk adder: {carry, sum} = X[j] + Yeff[j] + c_j.
        assign w_chunk = {1'b0, w_xin[j][j*c_cw +: c_cw]}
                       + {1'b0, w_yin[j][j*c_cw +: c_cw]}
                       + {{c_cw{1'b0}}, w_cin[j]};

        // Merge the new chunk into the lower chunks produced so far.
        always_comb begin
            w_sum                 = w_sumin[j];
            w_sum[j*c_cw +: c_cw] = w_chunk[c_cw-1:0];
        end

        if (j < k - 1) begin : g_mid
            always_ff @(posedge Clock) begin
                if (!Resetn) begin
                    r_v[j]   <= 1'b0;
                    r_c[j]   <= 1'b0;
                    r_sat[j] <= 1'b0;
                    r_sum[j] <= '0;
                    r_x[j]   <= '0;
                    r_y[j]   <= '0;
                end else if (w_adv) begin
                    r_v[j] <= w_vin[j];
                    // Data registers only load real beats; bubbles leave them.
                    if (w_vin[j]) begin
                        r_c[j]   <= w_chunk[c_cw];
                        r_sat[j] <= w_satin[j];
                        r_sum[j] <= w_sum;
                        r_x[j]   <= w_xin[j];
                        r_y[j]   <= w_yin[j];
                    end
                end
            end

            assign w_xin[j+1]   = r_x[j];
            assign w_yin[j+1]   = r_y[j];
            assign w_sumin[j+1] = r_sum[j];
            assign w_cin[j+1]   = r_c[j];
            assign w_satin[j+1] = r_sat[j];
            assign w_vin[j+1]   = r_v[j];
        end else begin : g_last
            logic         w_xmsb;
            logic         w_ymsb;
            logic         w_ovf;
            logic [n-1:0] w_clamp;
            logic [n-1:0] w_s;

            assign w_xmsb = w_xin[j][n-1];
            assign w_ymsb = w_yin[j][n-1];

            // Signed overflow: both addends share a sign the raw sum lacks.
            assign w_ovf = (w_xmsb & w_ymsb & ~w_sum[n-1])
                         | (~w_xmsb & ~w_ymsb & w_sum[n-1]);

            // A positive overflow wraps to a negative raw sum, so a set sign
            // bit means clamp to the positive extreme and vice versa.
            assign w_clamp = w_sum[n-1] ? {1'b0, {(n-1){1'b1}}}
                                        : {1'b1, {(n-1){1'b0}}};
            assign w_s     = (w_satin[j] & w_ovf) ? w_clamp : w_sum;

            always_ff @(posedge Clock) begin
                if (!Resetn) begin
                    r_v[j] <= 1'b0;
                    r_s    <= '0;
                    r_co   <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                    r_neg  <= 1'b0;
                end else if (w_adv) begin
                    r_v[j] <= w_vin[j];
                    if (w_vin[j]) begin
                        r_s    <= w_s;
                        r_co   <= w_chunk[c_cw];
                        r_ovf  <= w_ovf;
                        r_zero <= (w_s == '0);
                        r_neg  <= w_s[n-1];
                    end
                end
            end
        end
    end

    assign out_valid = r_v[k-1];
    assign S         = r_s;
    assign carryout  = r_co;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
//============================================================================
// Module   : tb_pipelined_addsub
// Purpose  : Self-checking bench for pipelined_addsub. Three instances
//            (n=8/k=2, n=8/k=1, n=32/k=4) share one stimulus stream; each
//            has its own scoreboard fed by an arithmetic reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_pipelined_addsub;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        z;
        logic        ng;
    } res_t;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        ordy;
    logic        sub;
    logic        sat;
    logic        cin;
    logic [31:0] x;
    logic [31:0] y;

    logic        ir_a, ov_a, co_a, ovf_a, z_a, ng_a;
    logic [7:0]  s_a;
    logic        ir_b, ov_b, co_b, ovf_b, z_b, ng_b;
    logic [7:0]  s_b;
    logic        ir_c, ov_c, co_c, ovf_c, z_c, ng_c;
    logic [31:0] s_c;

    int n_vec = 0;
    int n_err = 0;

    pipelined_addsub #(.n(8), .k(2)) dut_a (
        .Clock(clk), .Resetn(rstn), .in_valid(in_valid), .in_ready(ir_a),
        .Sub(sub), .Sat(sat), .carryin(cin), .X(x[7:0]), .Y(y[7:0]),
        .out_valid(ov_a), .out_ready(ordy), .S(s_a), .carryout(co_a),
        .overflow(ovf_a), .zero(z_a), .neg(ng_a));

    pipelined_addsub #(.n(8), .k(1)) dut_b (
        .Clock(clk), .Resetn(rstn), .in_valid(in_valid), .in_ready(ir_b),
        .Sub(sub), .Sat(sat), .carryin(cin), .X(x[7:0]), .Y(y[7:0]),
        .out_valid(ov_b), .out_ready(ordy), .S(s_b), .carryout(co_b),
        .overflow(ovf_b), .zero(z_b), .neg(ng_b));

    pipelined_addsub #(.n(32), .k(4)) dut_c (
        .Clock(clk), .Resetn(rstn), .in_valid(in_valid), .in_ready(ir_c),
        .Sub(sub), .Sat(sat), .carryin(cin), .X(x), .Y(y),
        .out_valid(ov_c), .out_ready(ordy), .S(s_c), .carryout(co_c),
        .overflow(ovf_c), .zero(z_c), .neg(ng_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on w-bit values.
    function automatic res_t model(input int w, input logic [31:0] xa, input logic [31:0] ya,
                                   input logic sb, input logic st, input logic ci);
        longint modv, half, ux, uy, sx, sy, full, tru, sval;
        res_t   r;
        modv = longint'(1) << w;
        half = modv / 2;
        ux   = longint'(xa) & (modv - 1);
        uy   = longint'(ya) & (modv - 1);
        sx   = (ux >= half) ? ux - modv : ux;
        sy   = (uy >= half) ? uy - modv : uy;
        if (!sb) begin
            full = ux + uy + longint'(ci);
            tru  = sx + sy + longint'(ci);
            r.co = (full >= modv);
        end else begin
            full = ux - uy - longint'(ci);
            tru  = sx - sy - longint'(ci);
            r.co = (full >= 0);
        end
        r.ovf = (tru > half - 1) || (tru < -half);
        if (st && r.ovf) sval = (tru > half - 1) ? half - 1 : -half;
        else             sval = full;
        sval = sval & (modv - 1);
        r.s  = 32'(sval);
        r.z  = (sval == 0);
        r.ng = 1'((sval >> (w - 1)) & 1);
        return r;
    endfunction

    //------------------------------------------------------------------------
    // Scoreboards, evaluated on the falling edge (inputs and outputs settled
    // for the coming rising edge).
    //------------------------------------------------------------------------
    res_t qa[$], qb[$], qc[$];
    res_t cur_a, cur_b, cur_c, prv_a, prv_b, prv_c;
    logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;

    always @(negedge clk) begin
        cur_a = {24'd0, s_a, co_a, ovf_a, z_a, ng_a};
        if (!rstn) begin
            qa.delete();
            st_a = 1'b0;
        end else begin
            if (st_a) check("a_hold", {ov_a, cur_a}, {1'b1, prv_a});
            if (ov_a && ordy) begin
                check("a_outq_nonempty", qa.size() != 0, 1'b1);
                if (qa.size() != 0) check("a_result", cur_a, qa.pop_front());
            end
            if (in_valid && ir_a) qa.push_back(model(8, x, y, sub, sat, cin));
            st_a  = ov_a & ~ordy;
            prv_a = cur_a;
        end
    end

    always @(negedge clk) begin
        cur_b = {24'd0, s_b, co_b, ovf_b, z_b, ng_b};
        if (!rstn) begin
            qb.delete();
            st_b = 1'b0;
        end else begin
            if (st_b) check("b_hold", {ov_b, cur_b}, {1'b1, prv_b});
            if (ov_b && ordy) begin
                check("b_outq_nonempty", qb.size() != 0, 1'b1);
                if (qb.size() != 0) check("b_result", cur_b, qb.pop_front());
            end
            if (in_valid && ir_b) qb.push_back(model(8, x, y, sub, sat, cin));
            st_b  = ov_b & ~ordy;
            prv_b = cur_b;
        end
    end

    always @(negedge clk) begin
        cur_c = {s_c, co_c, ovf_c, z_c, ng_c};
        if (!rstn) begin
            qc.delete();
            st_c = 1'b0;
        end else begin
            if (st_c) check("c_hold", {ov_c, cur_c}, {1'b1, prv_c});
            if (ov_c && ordy) begin
                check("c_outq_nonempty", qc.size() != 0, 1'b1);
                if (qc.size() != 0) check("c_result", cur_c, qc.pop_front());
            end
            if (in_valid && ir_c) qc.push_back(model(32, x, y, sub, sat, cin));
            st_c  = ov_c & ~ordy;
            prv_c = cur_c;
        end
    end

    //------------------------------------------------------------------------
    // Directed single beat: checks first-valid latency of all three
    // instances and the n=8/k=2 result against hand-computed values.
    //------------------------------------------------------------------------
    task automatic beat(input string tag, input logic [31:0] xa, input logic [31:0] ya,
                        input logic sb, input logic st, input logic ci,
                        input logic [7:0] es, input logic eco, input logic eov,
                        input logic ez, input logic en);
        int   la, lb, lc;
        res_t ga;
        la = 0; lb = 0; lc = 0; ga = '0;
        in_valid = 1'b1; x = xa; y = ya; sub = sb; sat = st; cin = ci;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (ov_a && la == 0) begin
                la = i;
                ga = {24'd0, s_a, co_a, ovf_a, z_a, ng_a};
            end
            if (ov_b && lb == 0) lb = i;
            if (ov_c && lc == 0) lc = i;
            @(posedge clk); #1;
        end
        check({tag, "_lat_k2"}, la, 2);
        check({tag, "_lat_k1"}, lb, 1);
        check({tag, "_lat_k4"}, lc, 4);
        check({tag, "_S"},  ga.s,   {24'd0, es});
        check({tag, "_co"}, ga.co,  eco);
        check({tag, "_ov"}, ga.ovf, eov);
        check({tag, "_z"},  ga.z,   ez);
        check({tag, "_ng"}, ga.ng,  en);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return m;
            2:       return m >> 1;
            3:       return (m >> 1) + 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    initial begin
        int ones, run, maxrun, wsel;
        logic hold;

        rstn = 1'b0; in_valid = 1'b0; ordy = 1'b1;
        sub = 1'b0; sat = 1'b0; cin = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov_a", ov_a, 1'b0);
        check("rst_S_a", s_a, 8'h00);
        check("rst_flags_a", {co_a, ovf_a, z_a, ng_a}, 4'b0000);
        check("rst_b", {ov_b, s_b, co_b, ovf_b, z_b, ng_b}, 13'd0);
        check("rst_c", {ov_c, s_c, co_c, ovf_c, z_c, ng_c}, 37'd0);
        rstn = 1'b1;

        beat("add0f01",   8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("add7f01",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        beat("add7f01s",  8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        beat("sub0001",   8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        beat("sub8001s",  8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        beat("sub0505b",  8'h05, 8'h05, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // Four back-to-back beats: expect four consecutive out_valid cycles.
        ones = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; x = 32'(8'h13 + 8'h31 * i); y = 32'(8'h25 * i);
                sub = 1'(i); sat = 1'b0; cin = 1'(i >> 1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (ov_a) begin ones++; run++; end else run = 0;
            if (run > maxrun) maxrun = run;
        end
        check("stream_count", ones, 4);
        check("stream_run", maxrun, 4);

        // Stall mid-stream: downstream blocks for three cycles.
        in_valid = 1'b1; x = 32'h41; y = 32'h17; sub = 1'b0;
        @(posedge clk); #1;
        x = 32'h90; y = 32'h22; sub = 1'b1;
        @(posedge clk); #1;
        x = 32'h7E; y = 32'h05; sub = 1'b0; sat = 1'b1;
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", ir_a, 1'b0);
            @(posedge clk); #1;
        end
        ordy = 1'b1;
        #1;
        for (int i = 0; i < 10 && !ir_a; i++) begin
            @(posedge clk); #1;
        end
        check("stall_release_ready", ir_a, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; sat = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("stall_drained_a", qa.size(), 0);

        // Reset with two beats in flight: nothing may emerge afterwards.
        ordy = 1'b0;
        in_valid = 1'b1; x = 32'h11; y = 32'h22; sub = 1'b0;
        @(posedge clk); #1;
        x = 32'h33; y = 32'h44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("midrst_ov_a", ov_a, 1'b0);
        check("midrst_S_a", s_a, 8'h00);
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", {ov_a, ov_b, ov_c}, 3'b000);
        end
        beat("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic with random backpressure and rare resets.
        hold = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!hold) begin
                in_valid = ($urandom_range(3) != 0);
                wsel     = ($urandom_range(1) != 0) ? 8 : 32;
                x   = pick(wsel);
                y   = pick(wsel);
                sub = 1'($urandom_range(1));
                sat = 1'($urandom_range(1));
                cin = 1'($urandom_range(1));
            end
            ordy = ($urandom_range(9) < 7);
            rstn = ($urandom_range(249) != 0);
            @(negedge clk);
            hold = rstn & in_valid & ~ir_a;
            @(posedge clk); #1;
        end

        rstn = 1'b1; in_valid = 1'b0; ordy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("final_drain_a", qa.size(), 0);
        check("final_drain_b", qb.size(), 0);
        check("final_drain_c", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the single-cycle n-bit adder with carry and overflow flags.
- Adds or subtracts two n-bit operands through a K-stage pipeline with a carry ripple of n/K bits per stage.
- Supports optional signed saturation and produces zero and negative flags.
- Ready/valid handshake on input and output, so it can feed datapath units that stall.

Parameters:
- n, 32, operand/result width in bits; n % k must be 0 (elaboration error otherwise).
- k, 4, number of pipeline stages / chunks; chunk width c = n/k; k=1 is legal (single registered stage).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- Sub  in  1  0 = add, 1 = subtract.
- Sat  in  1  1 = clamp signed overflow to the signed extreme.
- carryin  in  1  carry-in (add) / borrow-in (sub).
- X  in  n  operand A.
- Y  in  n  operand B.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- S  out  n  result.
- carryout  out  1  raw carry out of bit n-1 (sub: 1 = no borrow).
- overflow  out  1  signed overflow (before saturation).
- zero  out  1  S == 0 (after saturation).
- neg  out  1  S[n-1] (after saturation).

Behaviour:
- Reset (Resetn=0 at a rising edge): all stage valid bits, out_valid, S, carryout, overflow, zero and neg go to 0; partial sums are discarded. Reset mid-operation drops all in-flight beats, with no output afterwards.
- Advance: adv = ~out_valid | out_ready. in_ready = adv, combinational. When adv=0 every stage holds, including bubbles: the stall is global.
- Accept: in_valid & in_ready at an edge.
- Operand mapping:
  - Yeff = Y ^ {n{Sub}}.
  - cin = carryin ^ Sub.
  - Add gives X+Y+carryin; sub gives X−Y−carryin.
- Stage j (0..k-1) computes chunk j: {cj+1, Sj} = X[j] + Yeff[j] + cj, with c0 = cin.
  - The carry and upper operand chunks are registered forward to the next stage.
  - Lower result chunks are registered forward.
  - Sub, Sat and the operand MSBs travel with the beat.
- Latency: a beat accepted at edge t shows out_valid=1 after edge t+k-1. k=1 means one cycle.
  - Throughput: one beat per cycle when out_ready stays high.
- Final stage (registered with the result):
  - carryout = c_k.
  - overflow = (X[n-1] & Yeff[n-1] & ~R[n-1]) | (~X[n-1] & ~Yeff[n-1] & R[n-1]), where R is the raw sum.
  - If Sat & overflow: S = R[n-1] ? {0,1…1} : {1,0…0}. Otherwise S = R.
  - zero and neg are computed from the final S.
- Output hold: S and all flags stay stable while out_valid & ~out_ready.
- Wrap-around: without Sat the result is modulo 2^n, e.g. 0xFF+0x01 → 0x00, carryout=1.
- Simultaneous: accept and drain in the same cycle is allowed and loses no beat. in_valid while in_ready=0 is ignored; the source must hold the beat.
- X, Y, Sub, Sat and carryin are sampled only on accept.

Test Plan (n=8, k=2 unless noted):
- Add 0x0F+0x01, cin=0 → S=0x10, carryout=0, overflow=0, zero=0, neg=0; out_valid exactly 2 cycles after accept (checks carry crossing the chunk boundary).
- Add 0x7F+0x01 → S=0x80, overflow=1, neg=1. Same with Sat=1 → S=0x7F, overflow=1, neg=0.
- Sub 0x00−0x01 → S=0xFF, carryout=0, overflow=0. Sub 0x80−0x01 with Sat=1 → S=0x80, overflow=1, carryout=1. Sub 0x05−0x05 with carryin=1 → S=0xFF.
- Stream 4 back-to-back beats with out_ready=1 → 4 consecutive out_valid cycles with correct results in order. Then hold out_ready=0 for 3 cycles mid-stream → in_ready=0, S held, no beats lost or duplicated.
- Assert Resetn=0 for one edge with 2 beats in flight → out_valid=0 and S=0 next cycle, no stale results emerge. Then 0xFF+0x01 → S=0x00, carryout=1, zero=1.
- Parameter sweep with random operands against a reference model: k=1, n=8 (latency 1) and n=32, k=4 (latency 4).
